// File: rtl/reg_write_arbiter_if.sv
// Requester/bank-side bus of the round-robin register write arbiter.
// REG_ARB_LOCK_EN adds the per-requester lock request.
interface reg_write_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 32
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] data;
`ifdef REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        lock;
`endif
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REGS-1:0]       ce;
  logic [DATA_W-1:0]         wr_data;
  logic [ADDR_W-1:0]         wr_addr;
  logic [ID_W-1:0]           grant_id;
  logic                      wr_valid;
  logic                      addr_err;

`ifdef REG_ARB_LOCK_EN
  modport master (output req, addr, data, lock,
                  input  ack, ce, wr_data, wr_addr, grant_id, wr_valid, addr_err);
  modport slave  (input  req, addr, data, lock,
                  output ack, ce, wr_data, wr_addr, grant_id, wr_valid, addr_err);
`else
  modport master (output req, addr, data,
                  input  ack, ce, wr_data, wr_addr, grant_id, wr_valid, addr_err);
  modport slave  (input  req, addr, data,
                  output ack, ce, wr_data, wr_addr, grant_id, wr_valid, addr_err);
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing a register bank's CE/D write port among requesters.
// Optional REG_ARB_LOCK_EN: a granted requester may lock the port for back-to-back writes.
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 32
) (
  input logic                clk,
  input logic                rst,
  reg_write_arbiter_if.slave bus
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REGS-1:0] ce_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ID_W-1:0]     grant_id_q;
  logic                wr_valid_q;
  logic                addr_err_q;
  logic [ID_W-1:0]     last_q;

  logic [NUM_REQ-1:0]  lock_mask_c;
  logic [NUM_REQ-1:0]  elig_c;
  logic [NUM_REQ-1:0]  win_onehot_c;
  logic                any_c;
  logic                adv_last_c;
  logic                in_range_c;
  logic [ID_W-1:0]     win_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic [NUM_REGS-1:0] ce_c;
  int unsigned         dist_c;
  int unsigned         best_c;

  // A requester being acked this cycle is masked so a held req is not written twice.
  assign elig_c = bus.req & ~ack_q & lock_mask_c;

  // Winner is the eligible index at the smallest rotated distance past last_q.
  always_comb begin : arb
    any_c  = 1'b0;
    win_c  = '0;
    best_c = NUM_REQ;
    dist_c = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dist_c = i + NUM_REQ - 1 - 32'(last_q);
      if (dist_c >= NUM_REQ) dist_c = dist_c - NUM_REQ;
      if (elig_c[i] && (dist_c < best_c)) begin
        best_c = dist_c;
        win_c  = ID_W'(i);
        any_c  = 1'b1;
      end
    end
  end

  // Winner's address/data mux and one-hot clock enable decode.
  always_comb begin : sel
    win_onehot_c = '0;
    sel_addr_c   = '0;
    sel_data_c   = '0;
    ce_c         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_c) begin
        win_onehot_c[i] = any_c;
        sel_addr_c      = bus.addr[i*ADDR_W +: ADDR_W];
        sel_data_c      = bus.data[i*DATA_W +: DATA_W];
      end
    end
    in_range_c = (32'(sel_addr_c) < NUM_REGS);
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      ce_c[r] = any_c && (32'(sel_addr_c) == r);
    end
  end

`ifdef REG_ARB_LOCK_EN
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] owner_mask_c;
  logic               win_lock_c;

  always_comb begin : lock_sel
    owner_mask_c = '0;
    win_lock_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_mask_c[i] = (ID_W'(i) == owner_q);
      if (ID_W'(i) == win_c) win_lock_c = bus.lock[i];
    end
  end

  assign lock_mask_c = (state_q == ST_LOCKED) ? owner_mask_c : '1;
  assign adv_last_c  = (state_q == ST_UNLOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Lock is taken on a locked grant; released by an unlocked owner grant or an idle owner.
  always_comb begin : lock_fsm
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (any_c && win_lock_c) begin
          state_d = ST_LOCKED;
          owner_d = win_c;
        end
      end
      ST_LOCKED: begin
        if (any_c && !win_lock_c) begin
          state_d = ST_UNLOCKED;
        end else if (!(|(bus.req & owner_mask_c)) && !(|(ack_q & owner_mask_c))) begin
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end
`else
  assign lock_mask_c = '1;
  assign adv_last_c  = 1'b1;
`endif

  // Grant register: ack/ce/valid/err pulse for one cycle; data, address and id hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q      <= '0;
      ce_q       <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      grant_id_q <= '0;
      wr_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      last_q     <= ID_W'(NUM_REQ - 1);
    end else begin
      ack_q      <= '0;
      ce_q       <= '0;
      wr_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      if (any_c) begin
        ack_q      <= win_onehot_c;
        ce_q       <= ce_c;
        wr_valid_q <= 1'b1;
        addr_err_q <= !in_range_c;
        grant_id_q <= win_c;
        wr_addr_q  <= sel_addr_c;
        wr_data_q  <= sel_data_c;
        if (adv_last_c) last_q <= win_c;
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.ce       = ce_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.grant_id = grant_id_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed steps plus random traffic
// against a round-robin reference model and a behavioural register bank.
module tb_reg_write_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned NUM_REGS = 6;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                         .DATA_W(DATA_W)) bus ();
  reg_write_arbiter #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                      .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic              t_req  [NUM_REQ];
  logic [ADDR_W-1:0] t_addr [NUM_REQ];
  logic [DATA_W-1:0] t_data [NUM_REQ];
`ifdef REG_ARB_LOCK_EN
  logic              t_lock [NUM_REQ];
`endif

  always_comb begin
    bus.req  = '0;
    bus.addr = '0;
    bus.data = '0;
`ifdef REG_ARB_LOCK_EN
    bus.lock = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]                   = t_req[i];
      bus.addr[i*ADDR_W +: ADDR_W] = t_addr[i];
      bus.data[i*DATA_W +: DATA_W] = t_data[i];
`ifdef REG_ARB_LOCK_EN
      bus.lock[i]                  = t_lock[i];
`endif
    end
  end

  // Behavioural register bank fed by the arbiter's CE/D outputs.
  logic [DATA_W-1:0] bank [NUM_REGS];
  always @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) if (bus.ce[r]) bank[r] <= bus.wr_data;
  end

  // Reference model state.
  int                 m_last, m_grant, m_owner, pend_r;
  bit                 m_locked, pend;
  logic [NUM_REQ-1:0] m_ack;
  logic [DATA_W-1:0]  m_wr_data, pend_d;
  logic [ADDR_W-1:0]  m_wr_addr;
  logic [DATA_W-1:0]  m_bank    [NUM_REGS];
  bit                 m_written [NUM_REGS];
  logic [NUM_REQ-1:0]  e_ack;
  logic [NUM_REGS-1:0] e_ce;
  logic                e_valid, e_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last    = NUM_REQ - 1;
    m_grant   = 0;
    m_ack     = '0;
    m_wr_data = '0;
    m_wr_addr = '0;
    m_locked  = 1'b0;
    m_owner   = 0;
    pend      = 1'b0;
    e_ack     = '0;
    e_ce      = '0;
    e_valid   = 1'b0;
    e_err     = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ack"},      64'(bus.ack),      64'(e_ack));
    chk({tag, ".ce"},       64'(bus.ce),       64'(e_ce));
    chk({tag, ".wr_valid"}, 64'(bus.wr_valid), 64'(e_valid));
    chk({tag, ".addr_err"}, 64'(bus.addr_err), 64'(e_err));
    chk({tag, ".wr_data"},  64'(bus.wr_data),  64'(m_wr_data));
    chk({tag, ".wr_addr"},  64'(bus.wr_addr),  64'(m_wr_addr));
    chk({tag, ".grant_id"}, 64'(bus.grant_id), 64'(m_grant));
  endtask

  // Predict the next cycle from the current inputs, clock once, then compare.
  task automatic step(input string tag);
    logic [NUM_REQ-1:0] elig;
    logic [ADDR_W-1:0]  a;
    int                 w, j;
    bit                 was_locked;
    if (pend) begin
      m_bank[pend_r]    = pend_d;
      m_written[pend_r] = 1'b1;
      pend              = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = t_req[i] && !m_ack[i] && (!m_locked || i == m_owner);
    w = -1;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      j = (m_last + k) % int'(NUM_REQ);
      if (w < 0 && elig[j]) w = j;
    end
    was_locked = m_locked;
    e_ack = '0; e_ce = '0; e_valid = 1'b0; e_err = 1'b0;
    if (w >= 0) begin
      e_ack[w]  = 1'b1;
      e_valid   = 1'b1;
      m_grant   = w;
      a         = t_addr[w];
      m_wr_addr = a;
      m_wr_data = t_data[w];
      if (int'(a) < int'(NUM_REGS)) begin
        e_ce[a] = 1'b1;
        pend    = 1'b1;
        pend_r  = int'(a);
        pend_d  = t_data[w];
      end else begin
        e_err = 1'b1;
      end
      if (!was_locked) m_last = w;
`ifdef REG_ARB_LOCK_EN
      if (!m_locked && t_lock[w]) begin
        m_locked = 1'b1;
        m_owner  = w;
      end else if (m_locked && !t_lock[w]) begin
        m_locked = 1'b0;
      end
    end else if (m_locked && !t_req[m_owner] && !m_ack[m_owner]) begin
      m_locked = 1'b0;
`endif
    end
    m_ack = e_ack;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Idle or just-acked requesters may drop, or re-request with new addr/data.
  task automatic rand_update();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!t_req[i] || m_ack[i]) begin
        t_req[i]  = ($urandom_range(0, 2) != 0);
        t_addr[i] = ADDR_W'($urandom_range(0, 7));
        t_data[i] = $urandom;
`ifdef REG_ARB_LOCK_EN
        t_lock[i] = ($urandom_range(0, 3) == 0);
`endif
      end
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      t_req[i] = 1'b0;
`ifdef REG_ARB_LOCK_EN
      t_lock[i] = 1'b0;
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      t_addr[i] = '0;
      t_data[i] = '0;
    end
    for (int r = 0; r < NUM_REGS; r++) m_written[r] = 1'b0;
    clear_reqs();
    model_reset();
    rst = 1'b1;
    #2 rst = 1'b0;

    // Outputs stay zero in reset even with a request present.
    t_req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    t_req[0] = 1'b0;
    rst = 1'b1;

    // Single write to reg 5.
    t_req[0] = 1'b1; t_addr[0] = 3'd5; t_data[0] = 32'hDEADBEEF;
    step("first");
    chk("first.ack_const", 64'(bus.ack), 64'h1);
    chk("first.ce_const",  64'(bus.ce),  64'h20);
    chk("first.gid_const", 64'(bus.grant_id), 64'd0);
    t_req[0] = 1'b0;
    step("idle0");

    // All four continuously requesting: one write per cycle in rotation.
    for (int i = 0; i < NUM_REQ; i++) begin
      t_req[i] = 1'b1; t_addr[i] = ADDR_W'(i); t_data[i] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 8; k++) begin
      step("rr");
      chk("rr.gid_seq", 64'(bus.grant_id), 64'((k + 1) % NUM_REQ));
      chk("rr.valid",   64'(bus.wr_valid), 64'd1);
      for (int i = 0; i < NUM_REQ; i++) if (m_ack[i]) t_data[i] = t_data[i] + 32'h100;
    end
    clear_reqs();
    step("idle1");
    step("idle2");

    // Lone requester 2 re-requesting: served every other cycle.
    t_req[2] = 1'b1; t_addr[2] = 3'd4; t_data[2] = 32'h2222_0000;
    for (int k = 0; k < 8; k++) begin
      step("single");
      chk("single.ack2", 64'(bus.ack[2]), 64'(k % 2 == 0));
      if (m_ack[2]) t_data[2] = t_data[2] + 32'd1;
    end
    clear_reqs();
    step("idle3");

    // Out-of-range index: acked with addr_err, no clock enable.
    t_req[0] = 1'b1; t_addr[0] = 3'd7; t_data[0] = 32'h0BAD_0BAD;
    step("oor");
    chk("oor.ack_const", 64'(bus.ack), 64'h1);
    chk("oor.err_const", 64'(bus.addr_err), 64'd1);
    chk("oor.ce_const",  64'(bus.ce), 64'd0);
    t_req[0] = 1'b0;
    step("idle4");

    // Two writers to reg 2: last=0, so 1 then 0; requester 0's data remains.
    t_req[0] = 1'b1; t_addr[0] = 3'd2; t_data[0] = 32'hAAAA_0000;
    t_req[1] = 1'b1; t_addr[1] = 3'd2; t_data[1] = 32'hBBBB_0000;
    step("same1");
    t_req[1] = 1'b0;
    step("same2");
    t_req[0] = 1'b0;
    step("same3");
    step("same4");
    chk("same.bank2", 64'(bank[2]), 64'h0000_0000_AAAA_0000);

    for (int k = 0; k < 400; k++) begin
      rand_update();
      step("rand");
    end
    clear_reqs();
    step("idle5");
    step("idle6");

    // Reset in the ce cycle of a write to reg 3 drops ce/ack at once.
    t_req[3] = 1'b1; t_addr[3] = 3'd3; t_data[3] = 32'h3333_3333;
    step("rst_pre");
    chk("rst_pre.ce_const", 64'(bus.ce), 64'h08);
    t_req[3] = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) step("rst_post");

`ifdef REG_ARB_LOCK_EN
    // Requester 1 locks out 0 and 3 until it releases; then 3, then 0.
    t_req[0] = 1'b1; t_addr[0] = 3'd0; t_data[0] = 32'hC0C0_0000;
    step("lk_setup");
    t_req[0] = 1'b0;
    step("lk_idle");
    t_req[0] = 1'b1; t_data[0] = 32'hC0C0_0001;
    t_req[3] = 1'b1; t_addr[3] = 3'd3; t_data[3] = 32'hC3C3_0000;
    t_req[1] = 1'b1; t_addr[1] = 3'd1; t_data[1] = 32'hC1C1_0000; t_lock[1] = 1'b1;
    step("lk_g1");
    chk("lk_g1.gid", 64'(bus.grant_id), 64'd1);
    step("lk_wait1");
    chk("lk_wait1.valid", 64'(bus.wr_valid), 64'd0);
    step("lk_g1b");
    chk("lk_g1b.gid", 64'(bus.grant_id), 64'd1);
    t_lock[1] = 1'b0;
    step("lk_wait2");
    step("lk_g1c");
    chk("lk_g1c.gid", 64'(bus.grant_id), 64'd1);
    t_req[1] = 1'b0;
    step("lk_g3");
    chk("lk_g3.gid", 64'(bus.grant_id), 64'd3);
    t_req[3] = 1'b0;
    step("lk_g0");
    chk("lk_g0.gid", 64'(bus.grant_id), 64'd0);
    clear_reqs();
    step("lk_idle2");
    step("lk_idle3");
`endif

    for (int r = 0; r < NUM_REGS; r++)
      if (m_written[r]) chk($sformatf("bank[%0d]", r), 64'(bank[r]), 64'(m_bank[r]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the write port of a bank of NUM_REGS 32-bit clock-enabled registers among NUM_REQ requesters (e.g. pipeline stages, debug port).
- Arbitrates round-robin, then drives one-hot register clock enables plus a shared write-data bus for one cycle.
- Acknowledges each completed write back to its requester.
- Sits between the requesters and the register bank's CE/D inputs; the bank's own reset is independent.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- NUM_REGS, 8: number of registers in the bank.
- ADDR_W, 3: register index width; NUM_REGS <= 2**ADDR_W.
- DATA_W, 32: write data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; held until the matching ack.
- addr  input  NUM_REQ*ADDR_W  flattened target indices; requester i occupies bits [i*ADDR_W +: ADDR_W].
- data  input  NUM_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-cycle pulse to the granted requester.
- ce  output  NUM_REGS  one-hot register clock enables.
- wr_data  output  DATA_W  shared register D bus.
- wr_addr  output  ADDR_W  index of the write in flight.
- grant_id  output  $clog2(NUM_REQ)  winner of the last grant.
- wr_valid  output  1  a write is in flight this cycle.
- addr_err  output  1  pulse: the granted index was >= NUM_REGS.

Behaviour:
- Reset (rst=0, asynchronous):
  - ack=0, ce=0, wr_data=0, wr_addr=0, grant_id=0, wr_valid=0, addr_err=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
  - Lock state = UNLOCKED.
- Reset asserted mid-write: the pending ce/ack are dropped immediately and the write is lost. Requesters must re-request after reset.
- Arbitration:
  - Combinational over eligible = req & ~ack; a requester being acked this cycle is masked.
  - Search order is last+1, last+2, … modulo NUM_REQ; the first eligible index wins.
- Grant register (1-cycle latency):
  - On the edge after the winner is chosen: ack[w]=1, wr_valid=1, grant_id=w, wr_addr=addr[w], wr_data=data[w].
  - ce[addr[w]]=1 when addr[w] < NUM_REGS.
  - last=w.
  - All of these are registered outputs; ack and ce are high for exactly one cycle.
- Bank capture: the bank captures wr_data on the edge ending the ce cycle. Total latency from req sampled to register updated is 2 edges.
- No eligible requester: wr_valid=0, ce=0, ack=0; wr_data and wr_addr hold their previous values; last is unchanged.
- Requester protocol: drop or replace req/addr/data on the edge that ends its ack cycle.
  - A single continuous requester is served at most every other cycle.
  - With two or more requesters active, throughput is one write per cycle.
- Out-of-range index (addr[w] >= NUM_REGS): still granted and acked; ce stays all-zero; addr_err=1 for that cycle. The register bank is unchanged.
- Simultaneous requests to the same register index are serialized in round-robin order; the later grant wins the final value.
- Fairness: any continuously asserted req is granted within NUM_REQ grants.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- Defined:
  - Adds input lock[NUM_REQ] and a two-state machine, UNLOCKED/LOCKED.
  - UNLOCKED -> LOCKED(owner=w) when w is granted with lock[w]=1.
  - In LOCKED, only the owner is eligible; other requests wait, and last does not advance.
  - LOCKED -> UNLOCKED when either: the owner is granted with lock=0, or the owner has req=0 and ack=0 for a cycle.
  - Reset forces UNLOCKED.
- Not defined: no lock port; the arbiter is pure round-robin as above.

Test Plan:
- Reset release, then req=4'b0001, addr0=5, data0=32'hDEADBEEF -> next cycle: ack=0001, ce=8'b0010_0000, wr_data=DEADBEEF, wr_valid=1, grant_id=0. All outputs are 0 while rst=0.
- req=4'b1111 held continuously, distinct addrs -> grant_id sequence 0,1,2,3,0,…; one ce pulse per cycle; no requester starves.
- Single requester 2 holding req for 4 cycles (re-requesting after each ack) -> ack[2] pulses every other cycle; no double write from a stale req.
- req0 with addr=7 in a 6-register bank (NUM_REGS=6) -> ack[0]=1, addr_err=1, ce=0.
- rst pulled low in the ce cycle of a write to reg 3 -> ce and ack drop immediately. After release, with no req, wr_valid stays 0.
- REG_ARB_LOCK_EN: req1 granted with lock1=1 while req0/req3 are pending -> only 1 is granted until lock1=0. Then 3, then 0 are granted per round-robin from last=1.
